// File: rtl/fifo_flops.sv
// fifo_flops -- first-word-fall-through FIFO built from a flop array.
//
// Storage is a depth x bits register array addressed by circular write and
// read pointers, with an occupancy counter that drives the registered
// full/pndng flags. The head word is presented on Dout combinationally, so
// it is valid in the same cycle pndng rises, and Dout is forced to zero
// whenever the FIFO is empty, so stale array contents never leak out.
//
// Parameters:
//   depth  number of storage entries (2..256)
//   bits   data word width (1..64)
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst    asynchronous active-high reset
//   Din    write data, sampled when push=1
//   push   write request for this cycle
//   pop    read request for this cycle, consumes the word on Dout
//   Dout   head-of-queue word (zero when empty)
//   full   high when the FIFO holds depth words
//   pndng  high when the FIFO holds at least one word
//   count  current occupancy (only when FIFO_FLOPS_COUNT_EN is defined)
//
// Build option:
//   FIFO_FLOPS_COUNT_EN  exposes the occupancy counter on an extra port.

module fifo_flops #(
  parameter int depth = 8,
  parameter int bits  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] Din,
  input  logic            push,
  input  logic            pop,
  output logic [bits-1:0] Dout,
  output logic            full,
  output logic            pndng
`ifdef FIFO_FLOPS_COUNT_EN
  ,
  output logic [$clog2(depth+1)-1:0] count
`endif
);

  localparam int PtrW = $clog2(depth);
  localparam int CntW = $clog2(depth + 1);
  localparam logic [PtrW-1:0] LastIdx  = PtrW'(depth - 1);
  localparam logic [CntW-1:0] FullCnt  = CntW'(depth);

  logic [bits-1:0] mem_q [depth];

  logic [PtrW-1:0] wrPtr_q, wrPtr_d;
  logic [PtrW-1:0] rdPtr_q, rdPtr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, full_d;
  logic            pndng_q, pndng_d;

  logic doPush;
  logic doPop;

  // A push is accepted when there is room, or when the FIFO is full but a
  // pop in the same cycle frees the head slot. A pop only takes effect when
  // a word is actually pending; push+pop on an empty FIFO therefore stores
  // the new word only. Nothing is accepted while reset is held.
  always_comb begin
    doPush = push && (!full_q || pop) && !rst;
    doPop  = pop && pndng_q && !rst;
  end

  // Next-state for pointers, occupancy and the registered flags. The flags
  // are computed from the next occupancy so they change on the same edge
  // that changes the count.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;

    if (doPush) begin
      wrPtr_d = (wrPtr_q == LastIdx) ? '0 : wrPtr_q + PtrW'(1);
    end
    if (doPop) begin
      rdPtr_d = (rdPtr_q == LastIdx) ? '0 : rdPtr_q + PtrW'(1);
    end

    if (doPush && !doPop) begin
      count_d = count_q + CntW'(1);
    end else if (doPop && !doPush) begin
      count_d = count_q - CntW'(1);
    end

    full_d  = (count_d == FullCnt);
    pndng_d = (count_d != '0);
  end

  // Control state; reset takes effect immediately so the flags and Dout
  // drop to zero without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      pndng_q <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      full_q  <= full_d;
      pndng_q <= pndng_d;
    end
  end

  // Data array is deliberately left out of reset; the empty-gating on Dout
  // keeps any leftover contents invisible.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= Din;
    end
  end

  // Zero-latency head read, masked to zero when nothing is pending.
  always_comb begin
    Dout  = pndng_q ? mem_q[rdPtr_q] : '0;
    full  = full_q;
    pndng = pndng_q;
  end

`ifdef FIFO_FLOPS_COUNT_EN
  assign count = count_q;
`endif

endmodule

// File: tb/tb_fifo_flops.sv
// Self-checking bench for fifo_flops at depth=8, bits=16. Each scenario task
// drives directed stimulus and compares outputs against hand-computed values.
// Outputs are sampled 1 time unit after the rising edge.

module tb_fifo_flops;

  logic        clk;
  logic        rst;
  logic [15:0] Din;
  logic        push;
  logic        pop;
  logic [15:0] Dout;
  logic        full;
  logic        pndng;
`ifdef FIFO_FLOPS_COUNT_EN
  logic [3:0]  count;
`endif

  int errors = 0;
  int checks = 0;

  fifo_flops #(.depth(8), .bits(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .Din   (Din),
    .push  (push),
    .pop   (pop),
    .Dout  (Dout),
    .full  (full),
    .pndng (pndng)
`ifdef FIFO_FLOPS_COUNT_EN
    ,
    .count (count)
`endif
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of push/pop/Din, let the edge happen, then settle.
  task automatic applyStimulus(input logic p, input logic q, input logic [15:0] d);
    push = p;
    pop  = q;
    Din  = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    Din  = 16'h0000;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    push = 1'b0;
    pop  = 1'b0;
    Din  = 16'h0000;
    #2;
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got=%b exp=0", full); end
    checks++; if (pndng !== 1'b0) begin errors++; $display("[TB] FAIL reset_pndng got=%b exp=0", pndng); end
    checks++; if (Dout !== 16'h0000) begin errors++; $display("[TB] FAIL reset_dout got=%h exp=0000", Dout); end
`ifdef FIFO_FLOPS_COUNT_EN
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    applyStimulus(1'b1, 1'b0, 16'hA5A5);
    checks++; if (pndng !== 1'b1) begin errors++; $display("[TB] FAIL single_pndng got=%b exp=1", pndng); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL single_full got=%b exp=0", full); end
    checks++; if (Dout !== 16'hA5A5) begin errors++; $display("[TB] FAIL single_dout got=%h exp=a5a5", Dout); end
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checks++; if (pndng !== 1'b0) begin errors++; $display("[TB] FAIL single_pop_pndng got=%b exp=0", pndng); end
    checks++; if (Dout !== 16'h0000) begin errors++; $display("[TB] FAIL single_pop_dout got=%h exp=0000", Dout); end
    // Pop on empty must be ignored; a following push must show up at the head.
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checks++; if (pndng !== 1'b0) begin errors++; $display("[TB] FAIL empty_pop_pndng got=%b exp=0", pndng); end
    applyStimulus(1'b1, 1'b0, 16'h1234);
    checks++; if (Dout !== 16'h1234) begin errors++; $display("[TB] FAIL empty_pop_then_push got=%h exp=1234", Dout); end
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checks++; if (pndng !== 1'b0) begin errors++; $display("[TB] FAIL empty_pop_drain got=%b exp=0", pndng); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL fill_full_early i=%0d got=%b exp=0", i, full); end
      applyStimulus(1'b1, 1'b0, 16'(i));
`ifdef FIFO_FLOPS_COUNT_EN
      checks++; if (count !== 4'(i)) begin errors++; $display("[TB] FAIL fill_count got=%0d exp=%0d", count, i); end
`endif
    end
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full got=%b exp=1", full); end
    applyStimulus(1'b1, 1'b0, 16'h0009);
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL drop_full got=%b exp=1", full); end
    checks++; if (Dout !== 16'h0001) begin errors++; $display("[TB] FAIL drop_head got=%h exp=0001", Dout); end
    for (int i = 1; i <= 8; i++) begin
      checks++; if (Dout !== 16'(i)) begin errors++; $display("[TB] FAIL drain_order got=%h exp=%h", Dout, 16'(i)); end
      applyStimulus(1'b0, 1'b1, 16'h0000);
    end
    checks++; if (pndng !== 1'b0) begin errors++; $display("[TB] FAIL drain_pndng got=%b exp=0", pndng); end
    checks++; if (Dout !== 16'h0000) begin errors++; $display("[TB] FAIL drain_dout got=%h exp=0000", Dout); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 16'h0050 + 16'(i));
    for (int i = 0; i < 5; i++) begin
      checks++; if (Dout !== 16'h0050 + 16'(i)) begin errors++; $display("[TB] FAIL wrap_pre got=%h exp=%h", Dout, 16'h0050 + 16'(i)); end
      applyStimulus(1'b0, 1'b1, 16'h0000);
    end
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 16'h0100 + 16'(i));
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL wrap_full got=%b exp=1", full); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (Dout !== 16'h0100 + 16'(i)) begin errors++; $display("[TB] FAIL wrap_order got=%h exp=%h", Dout, 16'h0100 + 16'(i)); end
      applyStimulus(1'b0, 1'b1, 16'h0000);
    end
    checks++; if (pndng !== 1'b0) begin errors++; $display("[TB] FAIL wrap_empty got=%b exp=0", pndng); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b0, 16'(i));
    applyStimulus(1'b1, 1'b1, 16'h00FF);
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL pp_full_full got=%b exp=1", full); end
    checks++; if (Dout !== 16'h0002) begin errors++; $display("[TB] FAIL pp_full_head got=%h exp=0002", Dout); end
`ifdef FIFO_FLOPS_COUNT_EN
    checks++; if (count !== 4'd8) begin errors++; $display("[TB] FAIL pp_full_count got=%0d exp=8", count); end
`endif
    // Mid-occupancy push+pop keeps the count and advances both ends.
    applyStimulus(1'b0, 1'b1, 16'h0000);
    applyStimulus(1'b1, 1'b1, 16'h00EE);
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL pp_mid_full got=%b exp=0", full); end
    checks++; if (Dout !== 16'h0004) begin errors++; $display("[TB] FAIL pp_mid_head got=%h exp=0004", Dout); end
    for (int i = 4; i <= 8; i++) begin
      checks++; if (Dout !== 16'(i)) begin errors++; $display("[TB] FAIL pp_drain got=%h exp=%h", Dout, 16'(i)); end
      applyStimulus(1'b0, 1'b1, 16'h0000);
    end
    checks++; if (Dout !== 16'h00FF) begin errors++; $display("[TB] FAIL pp_drain_ff got=%h exp=00ff", Dout); end
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checks++; if (Dout !== 16'h00EE) begin errors++; $display("[TB] FAIL pp_drain_ee got=%h exp=00ee", Dout); end
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checks++; if (pndng !== 1'b0) begin errors++; $display("[TB] FAIL pp_drained got=%b exp=0", pndng); end
    applyStimulus(1'b1, 1'b1, 16'h0033);
    checks++; if (pndng !== 1'b1) begin errors++; $display("[TB] FAIL pp_empty_pndng got=%b exp=1", pndng); end
    checks++; if (Dout !== 16'h0033) begin errors++; $display("[TB] FAIL pp_empty_dout got=%h exp=0033", Dout); end
`ifdef FIFO_FLOPS_COUNT_EN
    checks++; if (count !== 4'd1) begin errors++; $display("[TB] FAIL pp_empty_count got=%0d exp=1", count); end
`endif
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checks++; if (pndng !== 1'b0) begin errors++; $display("[TB] FAIL pp_final got=%b exp=0", pndng); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 16'h0020 + 16'(i));
    checks++; if (Dout !== 16'h0020) begin errors++; $display("[TB] FAIL ar_pre_head got=%h exp=0020", Dout); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL ar_full got=%b exp=0", full); end
    checks++; if (pndng !== 1'b0) begin errors++; $display("[TB] FAIL ar_pndng got=%b exp=0", pndng); end
    checks++; if (Dout !== 16'h0000) begin errors++; $display("[TB] FAIL ar_dout got=%h exp=0000", Dout); end
`ifdef FIFO_FLOPS_COUNT_EN
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL ar_count got=%0d exp=0", count); end
`endif
    // Push held across an edge during reset must be ignored.
    push = 1'b1;
    Din  = 16'h0077;
    @(posedge clk);
    #1;
    checks++; if (pndng !== 1'b0) begin errors++; $display("[TB] FAIL ar_hold_pndng got=%b exp=0", pndng); end
    push = 1'b0;
    #2;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h0042);
    checks++; if (Dout !== 16'h0042) begin errors++; $display("[TB] FAIL ar_after_dout got=%h exp=0042", Dout); end
    checks++; if (pndng !== 1'b1) begin errors++; $display("[TB] FAIL ar_after_pndng got=%b exp=1", pndng); end
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checks++; if (pndng !== 1'b0) begin errors++; $display("[TB] FAIL ar_after_pop got=%b exp=0", pndng); end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_flops.md
FIFO_FLOPS -- requirements
Module: fifo_flops

Interface
REQ-001 Parameter depth, default 8: number of storage entries; legal range 2..256.
REQ-002 Parameter bits, default 16: data word width; legal range 1..64.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port Din  input  bits: write data, sampled on rising clk when push=1.
REQ-006 Port push  input  1: write request for the current cycle.
REQ-007 Port pop  input  1: read request for the current cycle; consumes the word on Dout.
REQ-008 Port Dout  output  bits: head-of-queue word, first-word-fall-through.
REQ-009 Port full  output  1: high when the FIFO holds depth words.
REQ-010 Port pndng  output  1: pending data; high when the FIFO holds at least 1 word.

Function
REQ-011 Storage SHALL be a flop array of depth x bits with circular write/read pointers and an occupancy counter 0..depth.
REQ-012 A push with full=0 SHALL store Din at the write pointer and advance it modulo depth at the clock edge.
REQ-013 A pop with pndng=1 SHALL advance the read pointer modulo depth at the clock edge.
REQ-014 Dout SHALL equal the oldest stored word whenever pndng=1, valid in the same cycle pndng rises (zero-cycle read latency).
REQ-015 Dout SHALL be all-zeros whenever pndng=0.
REQ-016 full and pndng SHALL be registered, derived from the occupancy counter, updated at the edge that changes occupancy.
REQ-017 Push while full with pop=0 SHALL be dropped; contents, pointers and flags unchanged.
REQ-018 Pop while empty SHALL be ignored; no pointer movement.
REQ-019 Push and pop together with 0<count<depth SHALL write and read in the same edge; count unchanged.
REQ-020 Push and pop together while empty SHALL accept the push only; count becomes 1.
REQ-021 Push and pop together while full SHALL pop the head and store Din; count stays depth; full stays 1.
REQ-022 Pointer wrap from depth-1 to 0 SHALL preserve strict FIFO order.

Reset
REQ-023 rst=1 SHALL immediately (asynchronously) clear pointers and count, force full=0, pndng=0, Dout=0.
REQ-024 Storage contents need not be cleared; stale data SHALL never appear on Dout after reset.
REQ-025 Reset asserted mid-operation SHALL discard all stored words; push/pop SHALL be ignored while rst=1.
REQ-026 The first push after rst deasserts SHALL be accepted on the next rising edge.

Configuration
REQ-027 When macro FIFO_FLOPS_COUNT_EN is defined, an extra output count SHALL be present, width $clog2(depth+1), equal to current occupancy and reset to 0.
REQ-028 Without FIFO_FLOPS_COUNT_EN the count port and its logic SHALL be absent; all other behaviour is identical.

Verification (depth=8, bits=16)
REQ-029 Reset then push 16'hA5A5 -> next cycle pndng=1, full=0, Dout=16'hA5A5; pop -> pndng=0, Dout=0.
REQ-030 Push 8 words 1..8 -> full=1 after the 8th edge; 9th push 16'h0009 is dropped; 8 pops return 1..8 in order, then pndng=0.
REQ-031 Wrap: push 5, pop 5, push 8 words 16'h0100..16'h0107 -> full=1; pops return 16'h0100..16'h0107 in order.
REQ-032 Simultaneous push+pop: full with head 1, push 16'h00FF+pop -> full stays 1, Dout=2; empty with push 16'h0033+pop -> pndng=1, Dout=16'h0033.
REQ-033 Assert rst asynchronously between edges with 4 words stored -> full=0, pndng=0, Dout=0 immediately; after release, push 16'h0042 -> Dout=16'h0042.
REQ-034 With FIFO_FLOPS_COUNT_EN: count tracks 0,1..8 on pushes, 8 on push+pop while full, 0 after reset.
